hero_frame_arb: RTL and testbench

- Parametrised N-channel hero-bus frame arbiter; next generation of the single-struct hero transfer.
- Each channel delivers beats tagged with a cycle type (IDLE/VALID/DONE) into a small per-channel FIFO.
- Round-robin arbiter locks onto one channel per frame and forwards that whole frame to a single output. Output ends at a DONE beat.
- Sits between hero-bus producers and the shared downstream consumer. Frame-length overrun is detected and truncated.

---
 rtl/hero_frame_pkg.sv | 29 ++
 rtl/hero_frame_fifo.sv | 49 ++++
 rtl/hero_frame_arb.sv | 203 ++++++++++++++++++++
 tb/tb_hero_frame_arb.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hero_frame_pkg.sv
// Shared types for the hero-bus frame arbiter: beat cycle tags, the
// default-width beat struct and the arbiter state encoding.
package hero_frame_pkg;

  localparam int HERO_FRAME_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    VALID = 2'd1,
    DONE  = 2'd2
  } cycle_type_e;

  typedef struct packed {
    logic [HERO_FRAME_DATA_W-1:0] data;
    cycle_type_e                  cycle;
  } hero_beat_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCKED = 2'd1,
    ARB_DRAIN  = 2'd2
  } arb_state_e;

  // IDLE and the reserved encoding are accepted but never stored
  function automatic logic is_stored(input logic [1:0] c);
    return (c == 2'(VALID)) || (c == 2'(DONE));
  endfunction

endpackage

// File: rtl/hero_frame_fifo.sv
// Single-channel synchronous FIFO, power-of-two depth, with an
// extra wrap bit on each pointer to tell full from empty.
module hero_frame_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp_q;
  logic [AW:0]      rp_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_wr) wp_q <= wp_q + 1'b1;
      if (do_rd) rp_q <= rp_q + 1'b1;
    end
  end

  // storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/hero_frame_arb.sv
// N-channel hero-bus frame arbiter: per-channel FIFOs, round-robin
// frame lock, overlength truncation. Optional HERO_FRAME_ARB_STATS_EN.
module hero_frame_arb
  import hero_frame_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_W-1:0]     in_data,
  input  logic [NUM_CH*2-1:0]          in_cycle,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [1:0]                   out_cycle,
  output logic [$clog2(NUM_CH)-1:0]    out_ch,
  output logic [$clog2(MAX_BEATS)-1:0] out_beat_idx,
  output logic                         err_overlen,
`ifdef HERO_FRAME_ARB_STATS_EN
  input  logic                         stat_clr,
  output logic [NUM_CH*16-1:0]         stat_frames,
`endif
  output logic [$clog2(NUM_CH)-1:0]    err_ch
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int BI_W = $clog2(MAX_BEATS);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    cycle_type_e       cycle;
  } beat_t;

  arb_state_e       state_q, state_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [BI_W-1:0]  idx_q, idx_d;
  logic             err_q, err_d;
  logic [CH_W-1:0]  errch_q, errch_d;
  logic             rdy_q;

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;
  beat_t             wr_b [NUM_CH];
  beat_t             rd_b [NUM_CH];

  beat_t            head;
  logic             found;
  logic [CH_W-1:0]  gnt;
  logic             trunc;
  logic             ov;
  logic [DATA_W-1:0] od;
  cycle_type_e      oc;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign in_ready[c] = rdy_q & ~full[c];
    assign wr_b[c] = '{
      data:  in_data[c*DATA_W +: DATA_W],
      cycle: cycle_type_e'(in_cycle[c*2 +: 2])
    };
    assign wr_en[c] = in_valid[c] & in_ready[c] &
                      is_stored(in_cycle[c*2 +: 2]);

    hero_frame_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[c]),
      .wr_data (wr_b[c]),
      .rd_en   (rd_en[c]),
      .rd_data (rd_b[c]),
      .full    (full[c]),
      .empty   (empty[c])
    );
  end

  // first non-empty channel at or after rr_q, wrapping
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && !empty[j]) begin
        found = 1'b1;
        gnt   = CH_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    errch_d = errch_q;
    rd_en   = '0;
    ov      = 1'b0;
    od      = '0;
    oc      = IDLE;
    trunc   = 1'b0;
    head    = rd_b[ch_q];
    unique case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d = ARB_LOCKED;
          ch_d    = gnt;
          idx_d   = '0;
          rr_d    = (gnt == CH_W'(NUM_CH-1)) ? '0 : gnt + 1'b1;
        end
      end
      ARB_LOCKED: begin
        ov    = !empty[ch_q];
        trunc = (idx_q == BI_W'(MAX_BEATS-1)) &&
                (head.cycle == VALID);
        if (ov) begin
          od = head.data;
          oc = trunc ? DONE : head.cycle;
        end
        if (ov && out_ready) begin
          rd_en[ch_q] = 1'b1;
          if (trunc) begin
            err_d   = 1'b1;
            errch_d = ch_q;
            state_d = ARB_DRAIN;
          end else if (head.cycle == DONE) begin
            state_d = ARB_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ARB_DRAIN: begin
        if (!empty[ch_q]) begin
          rd_en[ch_q] = 1'b1;
          if (head.cycle == DONE) state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      rr_q    <= '0;
      ch_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      errch_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      errch_q <= errch_d;
      rdy_q   <= 1'b1;
    end
  end

  assign out_valid    = ov;
  assign out_data     = od;
  assign out_cycle    = oc;
  assign out_ch       = ch_q;
  assign out_beat_idx = idx_q;
  assign err_overlen  = err_q;
  assign err_ch       = errch_q;

`ifdef HERO_FRAME_ARB_STATS_EN
  logic frame_done;
  assign frame_done = ov && out_ready && (oc == DONE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (stat_clr) begin
        cnt_q <= '0;
      end else if (frame_done && ch_q == CH_W'(c) &&
                   cnt_q != 16'hFFFF) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
    assign stat_frames[c*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_hero_frame_arb.sv
// Directed self-checking bench for hero_frame_arb (4 ch, 32b,
// depth 4, 16 beats max).
module tb_hero_frame_arb;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [127:0] in_data;
  logic [7:0]   in_cycle;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_cycle;
  logic [1:0]   out_ch;
  logic [3:0]   out_beat_idx;
  logic         err_overlen;
  logic [1:0]   err_ch;
`ifdef HERO_FRAME_ARB_STATS_EN
  logic         stat_clr;
  logic [63:0]  stat_frames;
`endif

  int n_chk;
  int n_fail;

  logic [31:0] pd [$];
  logic [1:0]  pc [$];
  logic [31:0] gd [$];
  logic [1:0]  gc [$];
  logic [3:0]  gi [$];
  logic [1:0]  gch [$];
  int          err_cnt;
  logic [1:0]  last_err_ch;

  hero_frame_arb #(
    .NUM_CH     (4),
    .DATA_W     (32),
    .FIFO_DEPTH (4),
    .MAX_BEATS  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_cycle     (in_cycle),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_cycle    (out_cycle),
    .out_ch       (out_ch),
    .out_beat_idx (out_beat_idx),
    .err_overlen  (err_overlen),
`ifdef HERO_FRAME_ARB_STATS_EN
    .stat_clr     (stat_clr),
    .stat_frames  (stat_frames),
`endif
    .err_ch       (err_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic produce(input int ch);
    for (int i = 0; i < pd.size(); i++) begin
      int g;
      g = 0;
      in_valid[ch] = 1'b1;
      in_data[ch*32 +: 32] = pd[i];
      in_cycle[ch*2 +: 2] = pc[i];
      while (!in_ready[ch] && g < 200) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (g >= 200) begin
        n_chk++; n_fail++;
        $display("FAIL produce_timeout ch%0d got in_ready=0 want 1", ch);
      end
      @(posedge clk);
      #1;
    end
    in_valid[ch] = 1'b0;
  endtask

  task automatic collect(input int ncyc);
    gd.delete(); gc.delete(); gi.delete(); gch.delete();
    err_cnt = 0;
    for (int k = 0; k < ncyc; k++) begin
      if (out_valid && out_ready) begin
        gd.push_back(out_data);
        gc.push_back(out_cycle);
        gi.push_back(out_beat_idx);
        gch.push_back(out_ch);
      end
      if (err_overlen) begin
        err_cnt++;
        last_err_ch = err_ch;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0;
    in_data = '0;
    in_cycle = '0;
    out_ready = 1'b0;
`ifdef HERO_FRAME_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_chk++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_chk++; if (out_cycle !== 2'd0) begin n_fail++; $display("FAIL rst_out_cycle got %0d want 0", out_cycle); end
    n_chk++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL rst_out_ch got %0d want 0", out_ch); end
    n_chk++; if (out_beat_idx !== 4'd0) begin n_fail++; $display("FAIL rst_beat_idx got %0d want 0", out_beat_idx); end
    n_chk++; if (err_overlen !== 1'b0) begin n_fail++; $display("FAIL rst_err_overlen got %b want 0", err_overlen); end
    n_chk++; if (err_ch !== 2'd0) begin n_fail++; $display("FAIL rst_err_ch got %0d want 0", err_ch); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (in_ready !== 4'hF) begin n_fail++; $display("FAIL rst_in_ready got %h want f", in_ready); end
`ifdef HERO_FRAME_ARB_STATS_EN
    n_chk++; if (stat_frames !== 64'h0) begin n_fail++; $display("FAIL rst_stats got %h want 0", stat_frames); end
`endif
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        in_valid[0] = 1'b1;
        in_data[31:0] = 32'hA000_0000 + 32'(k);
        in_cycle[1:0] = (k == 3) ? 2'd2 : 2'd1;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k == 0 || k == 5) begin
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_k%0d got %b want 0", k, out_valid); end
      end else begin
        n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_k%0d got %b want 1", k, out_valid); end
        n_chk++; if (out_data !== 32'hA000_0000 + 32'(k-1)) begin n_fail++; $display("FAIL single_data_k%0d got %h want %h", k, out_data, 32'hA000_0000 + 32'(k-1)); end
        n_chk++; if (out_beat_idx !== 4'(k-1)) begin n_fail++; $display("FAIL single_idx_k%0d got %0d want %0d", k, out_beat_idx, k-1); end
        n_chk++; if (out_cycle !== ((k == 4) ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL single_cycle_k%0d got %0d want %0d", k, out_cycle, (k == 4) ? 2 : 1); end
        n_chk++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL single_ch_k%0d got %0d want 0", k, out_ch); end
      end
    end
  endtask

  task automatic test_round_robin();
    int chs [3];
    logic [1:0] ech [6];
    logic [31:0] edat [6];
    chs = '{0, 1, 3};
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[chs[i]] = 1'b1;
        in_data[chs[i]*32 +: 32] = 32'hC000_0000 + 32'(chs[i]*256 + b);
        in_cycle[chs[i]*2 +: 2] = (b == 1) ? 2'd2 : 2'd1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = '0;
    for (int i = 0; i < 6; i++) begin
      ech[i] = 2'(chs[i/2]);
      edat[i] = 32'hC000_0000 + 32'(chs[i/2]*256 + i%2);
    end
    out_ready = 1'b1;
    collect(30);
    n_chk++; if (gd.size() !== 6) begin n_fail++; $display("FAIL rr_count got %0d want 6", gd.size()); end
    for (int i = 0; i < 6 && i < gd.size(); i++) begin
      n_chk++; if (gch[i] !== ech[i]) begin n_fail++; $display("FAIL rr_ch[%0d] got %0d want %0d", i, gch[i], ech[i]); end
      n_chk++; if (gd[i] !== edat[i]) begin n_fail++; $display("FAIL rr_data[%0d] got %h want %h", i, gd[i], edat[i]); end
      n_chk++; if (gc[i] !== ((i % 2 == 1) ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL rr_cycle[%0d] got %0d want %0d", i, gc[i], (i % 2 == 1) ? 2 : 1); end
    end
    in_valid[0] = 1'b1;
    in_data[31:0] = 32'hC100_0000;
    in_cycle[1:0] = 2'd2;
    in_valid[3] = 1'b1;
    in_data[127:96] = 32'hC100_0003;
    in_cycle[7:6] = 2'd2;
    @(posedge clk);
    #1;
    in_valid = '0;
    collect(12);
    n_chk++; if (gch.size() !== 2) begin n_fail++; $display("FAIL rr_wrap_count got %0d want 2", gch.size()); end
    if (gch.size() == 2) begin
      n_chk++; if (gch[0] !== 2'd0) begin n_fail++; $display("FAIL rr_wrap_first got ch%0d want ch0", gch[0]); end
      n_chk++; if (gch[1] !== 2'd3) begin n_fail++; $display("FAIL rr_wrap_second got ch%0d want ch3", gch[1]); end
    end
  endtask

  task automatic test_overlen();
    pd.delete(); pc.delete();
    for (int i = 0; i < 21; i++) begin
      pd.push_back(32'h2000_0000 + 32'(i));
      pc.push_back((i == 20) ? 2'd2 : 2'd1);
    end
    out_ready = 1'b1;
    fork
      produce(2);
      collect(80);
    join
    n_chk++; if (gd.size() !== 16) begin n_fail++; $display("FAIL ovl_count got %0d want 16", gd.size()); end
    for (int i = 0; i < 16 && i < gd.size(); i++) begin
      n_chk++; if (gd[i] !== 32'h2000_0000 + 32'(i)) begin n_fail++; $display("FAIL ovl_data[%0d] got %h want %h", i, gd[i], 32'h2000_0000 + 32'(i)); end
      n_chk++; if (gi[i] !== 4'(i)) begin n_fail++; $display("FAIL ovl_idx[%0d] got %0d want %0d", i, gi[i], i); end
      n_chk++; if (gc[i] !== ((i == 15) ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL ovl_cycle[%0d] got %0d want %0d", i, gc[i], (i == 15) ? 2 : 1); end
      n_chk++; if (gch[i] !== 2'd2) begin n_fail++; $display("FAIL ovl_ch[%0d] got %0d want 2", i, gch[i]); end
    end
    n_chk++; if (err_cnt !== 1) begin n_fail++; $display("FAIL ovl_err_pulses got %0d want 1", err_cnt); end
    n_chk++; if (last_err_ch !== 2'd2) begin n_fail++; $display("FAIL ovl_err_ch got %0d want 2", last_err_ch); end
    pd.delete(); pc.delete();
    pd.push_back(32'h2100_0000); pc.push_back(2'd1);
    pd.push_back(32'h2100_0001); pc.push_back(2'd2);
    fork
      produce(2);
      collect(15);
    join
    n_chk++; if (gd.size() !== 2) begin n_fail++; $display("FAIL ovl_next_count got %0d want 2", gd.size()); end
    for (int i = 0; i < 2 && i < gd.size(); i++) begin
      n_chk++; if (gd[i] !== 32'h2100_0000 + 32'(i)) begin n_fail++; $display("FAIL ovl_next_data[%0d] got %h want %h", i, gd[i], 32'h2100_0000 + 32'(i)); end
      n_chk++; if (gi[i] !== 4'(i)) begin n_fail++; $display("FAIL ovl_next_idx[%0d] got %0d want %0d", i, gi[i], i); end
    end
    n_chk++; if (err_cnt !== 0) begin n_fail++; $display("FAIL ovl_next_err got %0d want 0", err_cnt); end
    n_chk++; if (err_ch !== 2'd2) begin n_fail++; $display("FAIL ovl_err_ch_held got %0d want 2", err_ch); end
  endtask

  task automatic test_stall();
    logic [31:0] s_d;
    logic [1:0]  s_c;
    logic [3:0]  s_i;
    logic        stalled;
    int          left;
    pd.delete(); pc.delete();
    for (int i = 0; i < 8; i++) begin
      pd.push_back(32'h1000_0000 + 32'(i));
      pc.push_back((i == 7) ? 2'd2 : 2'd1);
    end
    gd.delete(); gc.delete(); gi.delete();
    stalled = 1'b0;
    left = 0;
    s_d = '0; s_c = '0; s_i = '0;
    out_ready = 1'b1;
    fork
      produce(1);
      for (int k = 0; k < 40; k++) begin
        if (!stalled && gd.size() == 2) begin
          out_ready = 1'b0;
          stalled = 1'b1;
          left = 5;
          s_d = out_data; s_c = out_cycle; s_i = out_beat_idx;
          n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_at_start got %b want 1", out_valid); end
        end else if (left > 0) begin
          n_chk++; if (out_valid !== 1'b1 || out_data !== s_d || out_cycle !== s_c || out_beat_idx !== s_i || out_ch !== 2'd1) begin
            n_fail++;
            $display("FAIL stall_hold left=%0d got v%b %h c%0d i%0d ch%0d want v1 %h c%0d i%0d ch1", left, out_valid, out_data, out_cycle, out_beat_idx, out_ch, s_d, s_c, s_i);
          end
          left--;
          if (left == 0) begin
            n_chk++; if (in_ready[1] !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", in_ready[1]); end
            out_ready = 1'b1;
          end
        end
        if (out_valid && out_ready) begin
          gd.push_back(out_data);
          gc.push_back(out_cycle);
          gi.push_back(out_beat_idx);
        end
        @(posedge clk);
        #1;
      end
    join
    n_chk++; if (gd.size() !== 8) begin n_fail++; $display("FAIL stall_count got %0d want 8", gd.size()); end
    for (int i = 0; i < 8 && i < gd.size(); i++) begin
      n_chk++; if (gd[i] !== 32'h1000_0000 + 32'(i) || gi[i] !== 4'(i)) begin n_fail++; $display("FAIL stall_beat[%0d] got %h/%0d want %h/%0d", i, gd[i], gi[i], 32'h1000_0000 + 32'(i), i); end
      n_chk++; if (gc[i] !== ((i == 7) ? 2'd2 : 2'd1)) begin n_fail++; $display("FAIL stall_cycle[%0d] got %0d want %0d", i, gc[i], (i == 7) ? 2 : 1); end
    end
  endtask

  task automatic test_idle_done();
    logic [31:0] ed [3];
    logic [3:0]  ei [3];
    logic [1:0]  ec [3];
    pd.delete(); pc.delete();
    pd.push_back(32'hDEAD_0000); pc.push_back(2'd0);
    pd.push_back(32'h0B00_0000); pc.push_back(2'd1);
    pd.push_back(32'hDEAD_0001); pc.push_back(2'd0);
    pd.push_back(32'hDEAD_0003); pc.push_back(2'd3);
    pd.push_back(32'h0B00_0001); pc.push_back(2'd2);
    pd.push_back(32'h0B00_0002); pc.push_back(2'd2);
    ed = '{32'h0B00_0000, 32'h0B00_0001, 32'h0B00_0002};
    ei = '{4'd0, 4'd1, 4'd0};
    ec = '{2'd1, 2'd2, 2'd2};
    out_ready = 1'b1;
    fork
      produce(0);
      collect(25);
    join
    n_chk++; if (gd.size() !== 3) begin n_fail++; $display("FAIL idle_count got %0d want 3", gd.size()); end
    for (int i = 0; i < 3 && i < gd.size(); i++) begin
      n_chk++; if (gd[i] !== ed[i]) begin n_fail++; $display("FAIL idle_data[%0d] got %h want %h", i, gd[i], ed[i]); end
      n_chk++; if (gi[i] !== ei[i]) begin n_fail++; $display("FAIL idle_idx[%0d] got %0d want %0d", i, gi[i], ei[i]); end
      n_chk++; if (gc[i] !== ec[i]) begin n_fail++; $display("FAIL idle_cycle[%0d] got %0d want %0d", i, gc[i], ec[i]); end
    end
  endtask

  task automatic test_reset_mid();
    pd.delete(); pc.delete();
    for (int i = 0; i < 3; i++) begin
      pd.push_back(32'h5000_0000 + 32'(i));
      pc.push_back(2'd1);
    end
    out_ready = 1'b0;
    produce(1);
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b1 || out_ch !== 2'd1) begin n_fail++; $display("FAIL rmid_locked got v%b ch%0d want v1 ch1", out_valid, out_ch); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async got %b want 0", out_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (in_ready !== 4'hF) begin n_fail++; $display("FAIL rmid_in_ready got %h want f", in_ready); end
    n_chk++; if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_beat_idx !== 4'd0) begin n_fail++; $display("FAIL rmid_state got v%b ch%0d i%0d want v0 ch0 i0", out_valid, out_ch, out_beat_idx); end
`ifdef HERO_FRAME_ARB_STATS_EN
    n_chk++; if (stat_frames !== 64'h0) begin n_fail++; $display("FAIL rmid_stats got %h want 0", stat_frames); end
`endif
    out_ready = 1'b1;
    in_valid[0] = 1'b1;
    in_data[31:0] = 32'h6000_0000;
    in_cycle[1:0] = 2'd2;
    in_valid[2] = 1'b1;
    in_data[95:64] = 32'h6000_0002;
    in_cycle[5:4] = 2'd2;
    @(posedge clk);
    #1;
    in_valid = '0;
    collect(12);
    n_chk++; if (gd.size() !== 2) begin n_fail++; $display("FAIL rmid_count got %0d want 2", gd.size()); end
    if (gd.size() == 2) begin
      n_chk++; if (gch[0] !== 2'd0 || gd[0] !== 32'h6000_0000) begin n_fail++; $display("FAIL rmid_first got ch%0d %h want ch0 60000000", gch[0], gd[0]); end
      n_chk++; if (gch[1] !== 2'd2 || gd[1] !== 32'h6000_0002) begin n_fail++; $display("FAIL rmid_second got ch%0d %h want ch2 60000002", gch[1], gd[1]); end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    err_cnt = 0;
    last_err_ch = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_overlen();
    test_stall();
    test_idle_done();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
